// File: rtl/ps2_rx_if.sv
// Result bundle of the PS/2 receiver: last good scan code plus one-cycle status pulses.
// The receiver drives it through the master modport; downstream logic reads it through slave.
interface ps2_rx_if;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output scan_code,
    output code_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input scan_code,
    input code_valid,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, then decodes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) into scan codes with error and timeout reporting.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a falling edge with data low (start bit)
//   DATA   | shifting in the 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking the stop bit, then publishing the code or an error
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic    CLOCK_50,
  input  logic    rst_n,
  input  logic    PS2_CLK,
  input  logic    PS2_DAT,
  ps2_rx_if.master rx
);

  localparam int RUN_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;

  logic [RUN_W-1:0] run;
  logic             filt;
  logic             filt_d;
  logic             fall;

  state_t      state, state_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        par_bit, par_nxt;
  logic [TO_W-1:0] to_cnt, to_nxt;
  logic [7:0]  scan_q, scan_nxt;
  logic        cv_q, cv_nxt;
  logic        pe_q, pe_nxt;
  logic        fe_q, fe_nxt;
  logic        busy_q;
  logic        timeout;

  // Synchronisers reset to the idle (released) line level.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Glitch filter: the level only follows after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      run    <= '0;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fall   <= 1'b0;
    end else begin
      filt_d <= filt;
      fall   <= filt_d & ~filt;
      if (clk_s != filt) begin
        if (run == RUN_W'(FILTER_LEN - 1)) begin
          filt <= clk_s;
          run  <= '0;
        end else begin
          run <= run + RUN_W'(1);
        end
      end else begin
        run <= '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      scan_q  <= 8'h00;
      cv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;
      to_cnt  <= to_nxt;
      scan_q  <= scan_nxt;
      cv_q    <= cv_nxt;
      pe_q    <= pe_nxt;
      fe_q    <= fe_nxt;
      busy_q  <= (state_nxt != IDLE);
    end
  end

  // A falling edge in the expiry cycle cancels the timeout.
  assign timeout = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par_bit;
    to_nxt      = to_cnt + TO_W'(1);
    scan_nxt    = scan_q;
    cv_nxt      = 1'b0;
    pe_nxt      = 1'b0;
    fe_nxt      = 1'b0;

    if (state == IDLE || fall) begin
      to_nxt = '0;
    end

    if (timeout) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      shreg_nxt   = '0;
      to_nxt      = '0;
      fe_nxt      = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          shreg_nxt   = {dat_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          par_nxt   = dat_s;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          // Exactly one outcome per frame; a bad stop bit outranks a parity failure.
          if (!dat_s) begin
            fe_nxt = 1'b1;
          end else if (((^shreg) ^ par_bit) == 1'b0) begin
            pe_nxt = 1'b1;
          end else begin
            scan_nxt = shreg;
            cv_nxt   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign rx.scan_code  = scan_q;
  assign rx.code_valid = cv_q;
  assign rx.parity_err = pe_q;
  assign rx.frame_err  = fe_q;
  assign rx.busy       = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: bit-banged PS/2 frames with hand-computed codes, latencies and error pulses.
// Runs with a shortened timeout and a fast PS/2 clock to keep the run short.
module tb_ps2_rx;
  localparam int H  = 25;   // CLOCK_50 cycles per PS/2 clock half-period
  localparam int TO = 300;  // shortened frame timeout

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  logic PS2_CLK  = 1'b1;
  logic PS2_DAT  = 1'b1;

  ps2_rx_if io();

  ps2_rx #(
    .SYNC_STAGES(2),
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst_n(rst_n),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .rx(io)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int pass_cnt = 0;
  int total    = 0;
  int cv_cnt   = 0;
  int pe_cnt   = 0;
  int fe_cnt   = 0;
  bit multi_hot = 1'b0;
  int lat_cv, lat_pe, lat_fe;
  int c_cv, c_pe, c_fe;
  int fe_at, busy_low_at, busy_seen;

  always @(negedge CLOCK_50) begin
    if (io.code_valid) cv_cnt++;
    if (io.parity_err) pe_cnt++;
    if (io.frame_err)  fe_cnt++;
    if ((int'(io.code_valid) + int'(io.parity_err) + int'(io.frame_err)) > 1) multi_hot = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic snap();
    c_cv = cv_cnt;
    c_pe = pe_cnt;
    c_fe = fe_cnt;
  endtask

  // One PS/2 bit; latencies count rising edges from the first one that samples PS2_CLK low (=1).
  task automatic ps2_bit(input logic d);
    PS2_DAT = d;
    repeat (H) @(posedge CLOCK_50);
    #1 PS2_CLK = 1'b0;
    lat_cv = 0;
    lat_pe = 0;
    lat_fe = 0;
    for (int n = 1; n <= H; n++) begin
      @(posedge CLOCK_50);
      #1;
      if (io.code_valid && lat_cv == 0) lat_cv = n;
      if (io.parity_err && lat_pe == 0) lat_pe = n;
      if (io.frame_err  && lat_fe == 0) lat_fe = n;
    end
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    ps2_bit(1'b0);
    check("busy_after_start", io.busy, 1);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stop);
    PS2_DAT = 1'b1;
    repeat (H) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_scan_code", io.scan_code, 8'h00);
    check("rst_code_valid", io.code_valid, 0);
    check("rst_parity_err", io.parity_err, 0);
    check("rst_frame_err", io.frame_err, 0);
    check("rst_busy", io.busy, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge CLOCK_50);

    // 0x1C: three ones, odd parity bit 0
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check("1c_latency", lat_cv, 12);
    check("1c_scan_code", io.scan_code, 8'h1C);
    check("1c_cv_pulses", cv_cnt - c_cv, 1);
    check("1c_no_errors", (pe_cnt - c_pe) + (fe_cnt - c_fe), 0);
    check("1c_busy_low", io.busy, 0);

    // back-to-back 0xF0 (parity 1) then 0x1C
    snap();
    send_frame(8'hF0, 1'b1, 1'b1);
    check("f0_scan_code", io.scan_code, 8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("b2b_scan_code", io.scan_code, 8'h1C);
    check("b2b_cv_pulses", cv_cnt - c_cv, 2);

    // 0x5A has four ones, so parity 0 is wrong
    snap();
    send_frame(8'h5A, 1'b0, 1'b1);
    check("5a_pe_pulses", pe_cnt - c_pe, 1);
    check("5a_pe_latency", lat_pe, 12);
    check("5a_no_cv", cv_cnt - c_cv, 0);
    check("5a_scan_kept", io.scan_code, 8'h1C);

    // 0x29 with correct parity 0 but stop bit 0
    snap();
    send_frame(8'h29, 1'b0, 1'b0);
    check("29_fe_pulses", fe_cnt - c_fe, 1);
    check("29_fe_latency", lat_fe, 12);
    check("29_no_pe_cv", (pe_cnt - c_pe) + (cv_cnt - c_cv), 0);
    check("29_scan_kept", io.scan_code, 8'h1C);

    // 5-cycle low glitch while idle must be filtered out
    snap();
    busy_seen = 0;
    PS2_CLK = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1 PS2_CLK = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge CLOCK_50);
      #1;
      if (io.busy) busy_seen++;
    end
    check("glitch_busy", busy_seen, 0);
    check("glitch_pulses", (cv_cnt - c_cv) + (pe_cnt - c_pe) + (fe_cnt - c_fe), 0);

    // start + 4 data bits then clock stays high: timeout
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    check("to_busy_mid_frame", io.busy, 1);
    fe_at = 0;
    busy_low_at = 0;
    for (int n = H + 1; n <= TO + 40; n++) begin
      @(posedge CLOCK_50);
      #1;
      if (io.frame_err && fe_at == 0) fe_at = n;
      if (!io.busy && busy_low_at == 0) busy_low_at = n;
    end
    check("to_fe_time", fe_at, TO + 12);
    check("to_busy_drop", busy_low_at, TO + 12);
    check("to_fe_pulses", fe_cnt - c_fe, 1);
    check("to_scan_kept", io.scan_code, 8'h1C);
    send_frame(8'h45, 1'b0, 1'b1);
    check("45_scan_code", io.scan_code, 8'h45);

    // reset after the 5th data bit of 0x66 (LSB first 0,1,1,0,0)
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("mrst_scan_code", io.scan_code, 8'h00);
    check("mrst_busy", io.busy, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("mrst_no_pulses", (cv_cnt - c_cv) + (pe_cnt - c_pe) + (fe_cnt - c_fe), 0);
    snap();
    send_frame(8'h66, 1'b1, 1'b1);
    check("66_scan_code", io.scan_code, 8'h66);
    check("66_cv_pulses", cv_cnt - c_cv, 1);
    check("66_latency", lat_cv, 12);

    check("pulses_exclusive", multi_hot, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
